// File: rtl/monitor_arbiter.sv
// monitor_arbiter: two-master Wishbone arbiter that shares the monitor RAM
// slave between the CPU instruction bus (m0) and the debug/data bus (m1).
// Grants are round-robin and stay locked for a whole bus cycle (cyc).
//
// Ports:
//   sys_clk, sys_rst_n        clock, asynchronous active-low reset
//   m0_* / m1_*               master Wishbone ports (adr/dat/sel/we/stb/cyc in,
//                             dat/ack/err out)
//   s_*                       muxed slave Wishbone port
//   grant_o                   one-hot grant status, 2'b00 when idle
//
// Optional feature: define MONITOR_ARB_WATCHDOG_EN to add a watchdog that
// terminates a stalled slave access with a one-cycle err pulse after TIMEOUT
// stalled cycles. Without it the err outputs are tied low.

module monitor_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,

  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_we_i,
  input  logic        m0_stb_i,
  input  logic        m0_cyc_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,

  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_we_i,
  input  logic        m1_stb_i,
  input  logic        m1_cyc_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,

  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic [3:0]  s_sel_o,
  output logic        s_we_o,
  output logic        s_stb_o,
  output logic        s_cyc_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,

  output logic [1:0]  grant_o
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;

  // Elaboration-time range check on the watchdog threshold.
  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("monitor_arbiter: TIMEOUT must be in 2..255");
  end

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e state_q, state_d;
  logic   gnt_q, gnt_d;     // 0 = m0, 1 = m1
  logic   last_q, last_d;   // last master served

  logic          req0, req1, busy;
  logic [AW-1:0] g_adr;
  logic [DW-1:0] g_dat;
  logic [SW-1:0] g_sel;
  logic          g_we, g_stb, g_cyc;
  logic          err_now;   // watchdog err cycle in progress
  logic          ack_ok;

  assign req0 = m0_cyc_i & m0_stb_i;
  assign req1 = m1_cyc_i & m1_stb_i;
  assign busy = (state_q == BUSY);

  // Granted master's request fields.
  always_comb begin
    g_adr = m0_adr_i;
    g_dat = m0_dat_i;
    g_sel = m0_sel_i;
    g_we  = m0_we_i;
    g_stb = m0_stb_i;
    g_cyc = m0_cyc_i;
    if (gnt_q) begin
      g_adr = m1_adr_i;
      g_dat = m1_dat_i;
      g_sel = m1_sel_i;
      g_we  = m1_we_i;
      g_stb = m1_stb_i;
      g_cyc = m1_cyc_i;
    end
  end

  // Next-state: round-robin on a tie, release when the granted cyc drops.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d = BUSY;
          gnt_d   = (req0 && req1) ? ~last_q : req1;
        end
      end
      BUSY: begin
        if (!g_cyc) begin
          state_d = IDLE;
          last_d  = gnt_q;
          gnt_d   = 1'b0;
        end
      end
    endcase
  end

  // State registers; reset makes m0 win the first tie.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

  // Slave-side mux; everything is zero while idle.
  assign s_adr_o = busy ? g_adr : '0;
  assign s_dat_o = busy ? g_dat : '0;
  assign s_sel_o = busy ? g_sel : '0;
  assign s_we_o  = busy & g_we;
  assign s_cyc_o = busy & g_cyc;
  assign s_stb_o = busy & g_stb & ~err_now;

  // Ack is routed only to the granted master; stray acks in IDLE vanish.
  assign ack_ok   = busy & s_ack_i & ~err_now;
  assign m0_ack_o = ack_ok & ~gnt_q;
  assign m1_ack_o = ack_ok &  gnt_q;

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  assign grant_o = busy ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;

`ifdef MONITOR_ARB_WATCHDOG_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
  logic             err_q, err_d;
  logic             stalled;

  // Only count while the access continues past this edge (cyc still high).
  assign stalled = busy & g_cyc & s_stb_o & ~s_ack_i;

  // Watchdog: terminal count raises err for one cycle and restarts the count.
  always_comb begin
    wd_cnt_d = '0;
    err_d    = 1'b0;
    if (stalled) begin
      if (wd_cnt_q == CNT_W'(TIMEOUT - 1)) begin
        err_d = 1'b1;
      end else begin
        wd_cnt_d = wd_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      err_q    <= err_d;
    end
  end

  assign err_now  = err_q;
  assign m0_err_o = err_q & ~gnt_q;
  assign m1_err_o = err_q &  gnt_q;
`else
  assign err_now  = 1'b0;
  assign m0_err_o = 1'b0;
  assign m1_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_monitor_arbiter.sv
// Directed testbench for monitor_arbiter with a small 2-stage-ack RAM slave.
module tb_monitor_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic [31:0] m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i;
  logic [3:0]  m0_sel_i, m1_sel_i;
  logic        m0_we_i, m0_stb_i, m0_cyc_i, m1_we_i, m1_stb_i, m1_cyc_i;
  logic [31:0] m0_dat_o, m1_dat_o;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic [31:0] s_adr_o, s_dat_o, s_dat_i;
  logic [3:0]  s_sel_o;
  logic        s_we_o, s_stb_o, s_cyc_o, s_ack_i;
  logic [1:0]  grant_o;

  int nv = 0;
  int nf = 0;

  always #5 clk = ~clk;

  monitor_arbiter #(.TIMEOUT(16)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i),
    .m0_stb_i(m0_stb_i), .m0_cyc_i(m0_cyc_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
    .m0_err_o(m0_err_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i),
    .m1_stb_i(m1_stb_i), .m1_cyc_i(m1_cyc_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
    .m1_err_o(m1_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .grant_o(grant_o)
  );

  // RAM slave: acks on the third cycle of a strobe; 'stall' suppresses acks.
  logic [31:0] mem [16];
  int unsigned scnt = 0;
  logic        stall = 1'b0;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'hA5A5_0000 | 32'(i);
    mem[0] = 32'h0;
    mem[4] = 32'h1234_5678;
  end

  assign s_ack_i = s_cyc_o & s_stb_o & ~stall & (scnt == 2);
  assign s_dat_i = mem[s_adr_o[5:2]];

  always @(posedge clk) begin
    if (s_ack_i && s_we_o)
      for (int b = 0; b < 4; b++)
        if (s_sel_o[b]) mem[s_adr_o[5:2]][8*b +: 8] <= s_dat_o[8*b +: 8];
    if (!s_stb_o || s_ack_i) scnt <= 0;
    else scnt <= scnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(input logic on, input logic [31:0] adr);
    m0_cyc_i = on; m0_stb_i = on; m0_adr_i = adr;
    m0_we_i = 1'b0; m0_sel_i = 4'hF; m0_dat_i = 32'h0;
  endtask

  task automatic drv1(input logic on, input logic [31:0] adr, input logic we,
                      input logic [31:0] dat, input logic [3:0] sel);
    m1_cyc_i = on; m1_stb_i = on; m1_adr_i = adr;
    m1_we_i = we; m1_sel_i = sel; m1_dat_i = dat;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    drv0(1'b0, 32'h0);
    drv1(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    nv++; if (grant_o !== 2'b00) begin nf++; $display("FAIL reset_grant got=%b exp=00", grant_o); end
    nv++; if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) begin nf++; $display("FAIL reset_cyc_stb got=%b%b exp=00", s_cyc_o, s_stb_o); end
    nv++; if (s_adr_o !== 32'h0 || s_we_o !== 1'b0) begin nf++; $display("FAIL reset_adr_we got=%h/%b exp=0/0", s_adr_o, s_we_o); end
    nv++; if ({m0_ack_o, m1_ack_o, m0_err_o, m1_err_o} !== 4'b0) begin nf++; $display("FAIL reset_ack_err got=%b exp=0000", {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}); end
  endtask

  task automatic test_single_read();
    logic [1:0] eg [6] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00};
    logic [5:0] estb = 6'b001110;
    logic [5:0] eack = 6'b001000;
    for (int c = 0; c < 6; c++) begin
      tick();
      drv0(c <= 3, 32'h0000_0010);
      @(negedge clk);
      nv++; if (grant_o !== eg[c]) begin nf++; $display("FAIL rd_grant c=%0d got=%b exp=%b", c, grant_o, eg[c]); end
      nv++; if (s_stb_o !== estb[c]) begin nf++; $display("FAIL rd_stb c=%0d got=%b exp=%b", c, s_stb_o, estb[c]); end
      nv++; if (m0_ack_o !== eack[c] || m1_ack_o !== 1'b0) begin nf++; $display("FAIL rd_ack c=%0d got=%b%b exp=0%b", c, m1_ack_o, m0_ack_o, eack[c]); end
      if (c == 3) begin
        nv++; if (m0_dat_o !== 32'h1234_5678) begin nf++; $display("FAIL rd_data got=%h exp=12345678", m0_dat_o); end
      end
      if (c == 1) begin
        nv++; if (s_adr_o !== 32'h10) begin nf++; $display("FAIL rd_adr got=%h exp=00000010", s_adr_o); end
      end
    end
  endtask

  task automatic test_tie();
    logic [1:0] eg [16] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10,
                            2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00};
    logic [15:0] a0 = 16'b0010_0000_0000_1000;
    logic [15:0] a1 = 16'b0000_0001_0000_0000;
    logic [15:0] ecyc = 16'h39CE;
    apply_reset();
    for (int c = 0; c < 16; c++) begin
      tick();
      drv0((c <= 3) || (c >= 5 && c <= 13), 32'h0000_0010);
      drv1(c <= 8, 32'h0000_0014, 1'b0, 32'h0, 4'hF);
      @(negedge clk);
      nv++; if (grant_o !== eg[c]) begin nf++; $display("FAIL tie_grant c=%0d got=%b exp=%b", c, grant_o, eg[c]); end
      nv++; if (s_cyc_o !== ecyc[c]) begin nf++; $display("FAIL tie_cyc c=%0d got=%b exp=%b", c, s_cyc_o, ecyc[c]); end
      nv++; if (m0_ack_o !== a0[c] || m1_ack_o !== a1[c]) begin nf++; $display("FAIL tie_ack c=%0d got=%b%b exp=%b%b", c, m1_ack_o, m0_ack_o, a1[c], a0[c]); end
      if (c == 8) begin
        nv++; if (m1_dat_o !== 32'hA5A5_0005) begin nf++; $display("FAIL tie_m1_data got=%h exp=a5a50005", m1_dat_o); end
      end
    end
  endtask

  task automatic test_locked_grant();
    logic [1:0] eg [17] = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10,
                            2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00};
    logic [16:0] a0 = 17'h04000;
    logic [16:0] a1 = 17'h00248;
    int k = 0;
    for (int c = 0; c < 17; c++) begin
      tick();
      drv0(c <= 14, 32'h0000_0010);
      drv1(c <= 9, 32'h0000_0020 + 32'(4 * k), 1'b0, 32'h0, 4'hF);
      @(negedge clk);
      nv++; if (grant_o !== eg[c]) begin nf++; $display("FAIL lock_grant c=%0d got=%b exp=%b", c, grant_o, eg[c]); end
      nv++; if (m0_ack_o !== a0[c] || m1_ack_o !== a1[c]) begin nf++; $display("FAIL lock_ack c=%0d got=%b%b exp=%b%b", c, m1_ack_o, m0_ack_o, a1[c], a0[c]); end
      if (a1[c]) begin
        nv++; if (m1_dat_o !== (32'hA5A5_0000 | 32'(8 + k))) begin nf++; $display("FAIL lock_data k=%0d got=%h exp=%h", k, m1_dat_o, 32'hA5A5_0000 | 32'(8 + k)); end
        k++;
      end
    end
    nv++; if (k != 3) begin nf++; $display("FAIL lock_ack_count got=%0d exp=3", k); end
  endtask

  task automatic test_write();
    for (int c = 0; c < 6; c++) begin
      tick();
      drv1(c <= 3, 32'h0000_1000, 1'b1, 32'hCAFE_BABE, 4'b0011);
      @(negedge clk);
      if (c == 1) begin
        nv++; if (s_sel_o !== 4'b0011) begin nf++; $display("FAIL wr_sel got=%b exp=0011", s_sel_o); end
        nv++; if (s_we_o !== 1'b1) begin nf++; $display("FAIL wr_we got=%b exp=1", s_we_o); end
        nv++; if (s_dat_o !== 32'hCAFE_BABE) begin nf++; $display("FAIL wr_dat got=%h exp=cafebabe", s_dat_o); end
        nv++; if (s_adr_o !== 32'h1000) begin nf++; $display("FAIL wr_adr got=%h exp=00001000", s_adr_o); end
      end
      if (c == 3) begin
        nv++; if (m1_ack_o !== 1'b1 || m0_ack_o !== 1'b0) begin nf++; $display("FAIL wr_ack got=%b%b exp=10", m1_ack_o, m0_ack_o); end
      end
      if (c == 5) begin
        nv++; if (grant_o !== 2'b00) begin nf++; $display("FAIL wr_idle got=%b exp=00", grant_o); end
      end
    end
    nv++; if (mem[0] !== 32'h0000_BABE) begin nf++; $display("FAIL wr_mem got=%h exp=0000babe", mem[0]); end
  endtask

  task automatic test_watchdog();
    logic exp_err;
    stall = 1'b1;
    for (int c = 0; c < 23; c++) begin
      tick();
      drv0(c <= 20, 32'h0000_0010);
      @(negedge clk);
`ifdef MONITOR_ARB_WATCHDOG_EN
      exp_err = (c == 17);
`else
      exp_err = 1'b0;
`endif
      if (c >= 1 && c <= 20) begin
        nv++; if (m0_err_o !== exp_err || m1_err_o !== 1'b0) begin nf++; $display("FAIL wd_err c=%0d got=%b%b exp=0%b", c, m1_err_o, m0_err_o, exp_err); end
        nv++; if (s_stb_o !== ~exp_err) begin nf++; $display("FAIL wd_stb c=%0d got=%b exp=%b", c, s_stb_o, ~exp_err); end
      end
    end
    stall = 1'b0;
    nv++; if (grant_o !== 2'b00) begin nf++; $display("FAIL wd_idle got=%b exp=00", grant_o); end
  endtask

  task automatic test_reset_mid();
    tick();
    drv0(1'b1, 32'h0000_0010);
    tick();
    @(negedge clk);
    nv++; if (s_stb_o !== 1'b1) begin nf++; $display("FAIL rm_stb_before got=%b exp=1", s_stb_o); end
    #1 rst_n = 1'b0;
    #1;
    nv++; if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) begin nf++; $display("FAIL rm_async_cyc_stb got=%b%b exp=00", s_cyc_o, s_stb_o); end
    nv++; if (grant_o !== 2'b00) begin nf++; $display("FAIL rm_async_grant got=%b exp=00", grant_o); end
    nv++; if (m0_ack_o !== 1'b0) begin nf++; $display("FAIL rm_ack got=%b exp=0", m0_ack_o); end
    drv0(1'b0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      drv0(c <= 1, 32'h0000_0010);
      drv1(c <= 1, 32'h0000_0014, 1'b0, 32'h0, 4'hF);
      @(negedge clk);
      if (c == 1) begin
        nv++; if (grant_o !== 2'b01) begin nf++; $display("FAIL rm_tie got=%b exp=01", grant_o); end
      end
    end
    // Both dropped at cycle 2; m1 was still requesting at that edge? No: both low.
    tick();
    @(negedge clk);
    nv++; if (grant_o !== 2'b00) begin nf++; $display("FAIL rm_idle got=%b exp=00", grant_o); end
  endtask

  initial begin
    apply_reset();
    test_reset();
    test_single_read();
    test_tie();
    test_locked_grant();
    test_write();
    test_watchdog();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nv, nf);
    $finish;
  end

endmodule

// File: doc/monitor_arbiter.md
# monitor_arbiter

Two-master Wishbone arbiter that shares the single-port monitor/gdbstub RAM slave between the CPU instruction bus (m0) and a debug/data bus (m1). It sits between the two masters and the monitor RAM slave. Grants are round-robin and locked for a whole bus cycle (`cyc`). Responses are routed back only to the granted master. An optional watchdog terminates slave accesses that stall.

## Interface
- `TIMEOUT`, default 16: stalled-strobe cycles before the watchdog fires; legal range 2..255.
- `sys_clk` in 1: system clock; all state updates on its rising edge.
- `sys_rst_n` in 1: asynchronous, active-low reset.
- `mN_adr_i` in 32 (N = 0, 1): master N address.
- `mN_dat_i` in 32: master N write data.
- `mN_sel_i` in 4: master N byte selects.
- `mN_we_i` in 1: master N write enable.
- `mN_stb_i`, `mN_cyc_i` in 1 each: master N strobe and cycle.
- `mN_dat_o` out 32: read data, equal to `s_dat_i` and broadcast to both masters.
- `mN_ack_o` out 1: acknowledge, asserted only to the granted master.
- `mN_err_o` out 1: watchdog error pulse to the granted master.
- `s_adr_o`, `s_dat_o` out 32 each: muxed address and write data to the slave.
- `s_sel_o` out 4; `s_we_o`, `s_stb_o`, `s_cyc_o` out 1 each: muxed controls to the slave.
- `s_dat_i` in 32; `s_ack_i` in 1: slave read data and acknowledge.
- `grant_o` out 2: one-hot grant status; `2'b00` when idle.

## Operation
- FSM states: IDLE and BUSY. Registers: `gnt` (which master), `last` (last-served master).
- **IDLE.** A request from master N is `mN_cyc_i & mN_stb_i`.
  - One request: grant that master, go to BUSY.
  - Both request: grant the master that is not `last`.
- **BUSY.**
  - The granted master's `adr`, `dat`, `sel`, `we`, `stb` and `cyc` drive the `s_*` outputs combinationally.
  - `s_ack_i` goes combinationally to the granted `mN_ack_o` only. The other master sees ack = 0 and err = 0.
  - The grant is held across any number of `stb` phases while the granted `cyc` stays high. The other master waits.
- **Release.** When the granted `mN_cyc_i` is low at a clock edge: go to IDLE, set `last` to the granted master, clear `gnt`.
- **Non-granted outputs.** In IDLE, all `s_*` outputs are 0. `mN_dat_o` is always `s_dat_i`.
- **Reset values.** IDLE, `grant_o` = 0, `last` = m1 (so m0 wins the first tie). All `s_*` outputs, acks and errs are 0. Watchdog counter is 0.
- **Reset mid-transaction.** The grant is dropped immediately (asynchronously) and `s_cyc_o`/`s_stb_o` go low. The slave's in-flight ack is discarded.
- **Stray ack.** `s_ack_i` arriving in IDLE is ignored.

## Timing
- **Grant latency.** Request sampled at edge E; `s_stb_o` is high in the cycle after E.
- **Acknowledge.** Combinational pass-through from `s_ack_i`, zero added latency. A single monitor RAM read or write is complete 3 cycles after `s_stb_o` first rises (the slave's 2-stage ack).
- **Handover.** Granted `cyc` drops before edge E. The fsm is IDLE in the cycle after E, and the waiting master is granted at the following edge. Minimum gap between masters is 2 cycles with `s_cyc_o` low.
- **Simultaneous release and new request.** The IDLE cycle is always inserted; there are no back-to-back grants across masters.

## Configuration
- Macro: `MONITOR_ARB_WATCHDOG_EN`.
- **Defined:**
  - A counter of `$clog2(TIMEOUT)` bits increments at each edge where `s_stb_o & ~s_ack_i` in BUSY.
  - The counter clears on `s_ack_i`, on `s_stb_o` low, and on leaving BUSY.
  - At an edge where the counter equals TIMEOUT-1, `err` is registered high for exactly one cycle to the granted master and the counter clears.
  - During that err cycle, `s_stb_o` is forced 0 and any `s_ack_i` is suppressed.
  - If `s_ack_i` and the terminal count coincide, ack wins and no err is raised.
- **Undefined:** `mN_err_o` are tied to 0, no counter exists, and a stalled slave holds the grant indefinitely.

## Test plan
1. **Single read.** After reset, m0 reads addr `0x0000_0010` (RAM word 4 = `0x1234_5678`) → `s_stb_o` high 1 cycle after the request. `m0_ack_o` pulses once, 3 cycles later, with `m0_dat_o = 0x1234_5678`. `grant_o` = `01`, then `00` after `cyc` drops.
2. **Tie.** m0 and m1 request in the same cycle, right after reset → m0 is served first. m1 is granted 2 cycles after m0's `cyc` falls. On the next tie, m1 wins.
3. **Locked grant.** m1 holds `cyc` and issues 3 back-to-back strobes while m0 requests → three m1 acks. `m0_ack_o` stays 0 throughout. m0 is granted only after m1 drops `cyc`.
4. **Write pass-through.** m1 writes `0xCAFEBABE` with `sel = 4'b0011` to addr `0x1000` → `s_sel_o = 4'b0011`, `s_we_o = 1`, `s_dat_o = 0xCAFEBABE`. The ack goes to m1 only.
5. **Watchdog, macro defined, TIMEOUT = 16.** The slave never acks and `stb` is first seen at cycle T → `m0_err_o` is high in cycle T+16 only, with `s_stb_o` low that cycle. With the macro undefined, err is never asserted.
6. **Reset mid-access.** `sys_rst_n` is pulled low mid-access → `s_cyc_o`, `s_stb_o` and `grant_o` go to 0 without waiting for a clock. After release, the next tie goes to m0.
